// File: rtl/instr_mem_stream_pkg.sv
// Shared defaults and helpers for the fetch-stage instruction memory.
//   IMEM_DATA_BITS  : instruction word width (multiple of 8)
//   IMEM_ADDR_BITS  : word-address width
//   IMEM_SIZE       : number of instruction words
//   IMEM_RSP_DEPTH  : response FIFO entries
package instr_mem_stream_pkg;

  localparam int unsigned IMEM_DATA_BITS = 32;
  localparam int unsigned IMEM_ADDR_BITS = 10;
  localparam int unsigned IMEM_SIZE      = 1024;
  localparam int unsigned IMEM_RSP_DEPTH = 4;

  // Index width for n entries, never below one bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/instr_mem_stream_rsp_fifo.sv
// Response FIFO for the instruction memory. Circular buffer whose pointers
// wrap at DEPTH, which need not be a power of two.
//   clk, rst_n  : clock, asynchronous active-low reset
//   push        : write push_data at the tail (suppressed while flush is high)
//   pop         : consume the head entry (ignored when empty)
//   flush       : drop every queued entry
//   cnt         : number of queued entries
//   head_valid  : cnt != 0
//   head_data   : head entry, zero when empty
module instr_rsp_fifo
  import instr_mem_stream_pkg::*;
#(
  parameter int unsigned WIDTH = IMEM_DATA_BITS + 1,
  parameter int unsigned DEPTH = IMEM_RSP_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] cnt,
  output logic                       head_valid,
  output logic [WIDTH-1:0]           head_data
);

  localparam int unsigned PW = clog2_min1(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] store [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push = push && !flush;
  assign do_pop  = pop && (cnt_q != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      // Dropping everything means the head catches up with the tail.
      cnt_q  <= '0;
      rd_ptr <= wr_ptr;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) store[wr_ptr] <= push_data;
  end

  assign cnt        = cnt_q;
  assign head_valid = (cnt_q != '0);
  // Gating keeps the unreset storage from reaching the outputs.
  assign head_data  = head_valid ? store[rd_ptr] : '0;

endmodule

// File: rtl/instr_mem_stream.sv
// Pipelined instruction memory for the fetch stage: valid/ready fetch
// requests, a one-entry read stage feeding a response FIFO, a byte-strobed
// program-load write port, out-of-range detection and a redirect flush.
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : fetch request handshake, req_addr = word address
//   rsp_valid/rsp_ready  : response handshake, rsp_data = word,
//                          rsp_err = address was >= MEM_SIZE
//   wr_en/wr_addr/wr_data/wr_strb : program-load write, byte i on wr_strb[i]
//   flush                : discard in-flight and queued responses
module instr_mem_stream
  import instr_mem_stream_pkg::*;
#(
  parameter int unsigned DATA_BITS = IMEM_DATA_BITS,
  parameter int unsigned ADDR_BITS = IMEM_ADDR_BITS,
  parameter int unsigned MEM_SIZE  = IMEM_SIZE,
  parameter int unsigned RSP_DEPTH = IMEM_RSP_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [ADDR_BITS-1:0]   req_addr,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_BITS-1:0]   rsp_data,
  output logic                   rsp_err,
  input  logic                   wr_en,
  input  logic [ADDR_BITS-1:0]   wr_addr,
  input  logic [DATA_BITS-1:0]   wr_data,
  input  logic [DATA_BITS/8-1:0] wr_strb,
  input  logic                   flush
);

  localparam int unsigned NB = DATA_BITS / 8;
  localparam int unsigned IW = clog2_min1(MEM_SIZE);
  localparam int unsigned CW = $clog2(RSP_DEPTH + 1);
  localparam logic [ADDR_BITS:0] SIZE_L  = (ADDR_BITS + 1)'(MEM_SIZE);
  localparam logic [CW:0]        DEPTH_L = (CW + 1)'(RSP_DEPTH);

  logic [DATA_BITS-1:0] mem [MEM_SIZE];

  logic                 req_in_range;
  logic                 wr_in_range;
  logic                 req_fire;
  logic                 inflight;
  logic [DATA_BITS-1:0] rd_data;
  logic                 rd_err;
  logic [CW-1:0]        fifo_cnt;
  logic [CW:0]          occupancy;
  logic [DATA_BITS:0]   head;

  assign req_in_range = ({1'b0, req_addr} < SIZE_L);
  assign wr_in_range  = ({1'b0, wr_addr} < SIZE_L);

  // Credits cover queued entries plus the read stage, so a stalled consumer
  // can never overflow the FIFO; only registered state feeds this.
  assign occupancy = {1'b0, fifo_cnt} + {{CW{1'b0}}, inflight};
  assign req_ready = !flush && (occupancy < DEPTH_L);
  assign req_fire  = req_valid && req_ready;

  // Storage has no reset; the read stage samples mem before this write lands,
  // giving read-first behaviour on a same-address collision.
  always_ff @(posedge clk) begin
    if (wr_en && wr_in_range) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (wr_strb[b]) mem[wr_addr[IW-1:0]][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight <= 1'b0;
      rd_data  <= '0;
      rd_err   <= 1'b0;
    end else if (flush) begin
      inflight <= 1'b0;
    end else begin
      inflight <= req_fire;
      if (req_fire) begin
        rd_data <= req_in_range ? mem[req_addr[IW-1:0]] : '0;
        rd_err  <= !req_in_range;
      end
    end
  end

  instr_rsp_fifo #(
    .WIDTH (DATA_BITS + 1),
    .DEPTH (RSP_DEPTH)
  ) u_rsp_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push       (inflight),
    .push_data  ({rd_err, rd_data}),
    .pop        (rsp_valid && rsp_ready),
    .flush      (flush),
    .cnt        (fifo_cnt),
    .head_valid (rsp_valid),
    .head_data  (head)
  );

  assign rsp_data = head[DATA_BITS-1:0];
  assign rsp_err  = head[DATA_BITS];

endmodule

// File: tb/tb_instr_mem_stream.sv
module tb_instr_mem_stream;

  localparam int DEPTH = 4;
  localparam int MSIZE = 512;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [9:0]  req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        wr_en;
  logic [9:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        flush;

  instr_mem_stream #(
    .DATA_BITS (32),
    .ADDR_BITS (10),
    .MEM_SIZE  (MSIZE),
    .RSP_DEPTH (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .wr_en     (wr_en),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_strb   (wr_strb),
    .flush     (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: memory image plus an ordered list of outstanding
  // fetches, each tagged with the edge that accepted it.
  typedef struct {
    logic [31:0] d;
    logic        err;
    int          acc;
  } ent_t;

  logic [31:0] mm [1024];
  ent_t        mq [$];
  ent_t        ne;
  int          ecount = 0;
  bit          m_acc;
  bit          m_pop;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
    end else begin
      m_acc = req_valid && !flush && (mq.size() < DEPTH);
      m_pop = (mq.size() > 0) && (mq[0].acc < ecount) && rsp_ready;
      if (m_acc) begin
        ne.err = (int'(req_addr) >= MSIZE);
        ne.d   = ne.err ? 32'h0 : mm[req_addr];
      end
      ecount++;
      if (flush) begin
        mq.delete();
      end else begin
        if (m_pop) void'(mq.pop_front());
        if (m_acc) begin
          ne.acc = ecount;
          mq.push_back(ne);
        end
      end
      if (wr_en && int'(wr_addr) < MSIZE)
        for (int b = 0; b < 4; b++)
          if (wr_strb[b]) mm[wr_addr][8*b +: 8] = wr_data[8*b +: 8];
    end
  end

  int          errs = 0;
  int          checks = 0;
  logic [32:0] got [$];
  logic [31:0] pre [32];
  bit          exp_v;
  bit          a;
  int          k;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [9:0] ad, input logic [31:0] d, input logic [3:0] s);
    wr_en = 1'b1; wr_addr = ad; wr_data = d; wr_strb = s;
    tick();
    wr_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_strb = '0; flush = 1'b0;

    fork
      forever begin
        @(negedge clk);
        exp_v = rst_n && (mq.size() > 0) && (mq[0].acc < ecount);
        chk("req_ready", req_ready, !flush && (mq.size() < DEPTH));
        chk("rsp_valid", rsp_valid, exp_v);
        if (exp_v) begin
          chk("rsp_data", rsp_data, mq[0].d);
          chk("rsp_err", rsp_err, mq[0].err);
        end else if (!rst_n) begin
          chk("rst_rsp_data", rsp_data, 0);
          chk("rst_rsp_err", rsp_err, 0);
        end
        if (rsp_valid && rsp_ready && rst_n) got.push_back({rsp_err, rsp_data});
      end
    join_none

    // Reset and first fetch
    repeat (3) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_rsp_data", rsp_data, 0);
    chk("reset_req_ready", req_ready, 1);
    tick();
    for (int i = 0; i < 32; i++) begin
      pre[i] = $urandom;
      wr(10'(i), pre[i], 4'hf);
    end
    pre[5] = 32'h0050_0093; wr(10'd5, pre[5], 4'hf);
    pre[8] = 32'hFFFF_FFFF; wr(10'd8, pre[8], 4'hf);
    wr(10'd88, 32'hA5A5_A5A5, 4'hf);

    req_valid = 1'b1; req_addr = 10'd5;
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("fetch_lat_n1", rsp_valid, 0);
    tick();
    @(negedge clk);
    chk("fetch_valid", rsp_valid, 1);
    chk("fetch_data", rsp_data, 32'h0050_0093);
    chk("fetch_err", rsp_err, 0);
    tick();

    // Streaming
    got.delete();
    for (int i = 0; i < 16; i++) begin
      req_valid = 1'b1; req_addr = 10'(i);
      @(negedge clk);
      chk("stream_ready", req_ready, 1);
      if (i >= 2) chk("stream_rsp_valid", rsp_valid, 1);
      tick();
    end
    req_valid = 1'b0;
    repeat (4) tick();
    chk("stream_count", got.size(), 16);
    chk("stream_last", got[15], {1'b0, pre[15]});

    // Backpressure
    got.delete();
    rsp_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 10; c++) begin
      req_valid = 1'b1; req_addr = 10'(20 + k);
      @(negedge clk);
      a = req_ready;
      tick();
      if (a) k++;
    end
    @(negedge clk);
    chk("bp_accepts", k, 4);
    chk("bp_ready_low", req_ready, 0);
    tick();
    rsp_ready = 1'b1;
    for (int c = 0; c < 30 && k < 6; c++) begin
      req_valid = 1'b1; req_addr = 10'(20 + k);
      @(negedge clk);
      a = req_ready;
      tick();
      if (a) k++;
    end
    req_valid = 1'b0;
    chk("bp_release", k, 6);
    repeat (6) tick();
    chk("bp_count", got.size(), 6);
    for (int i = 0; i < 6; i++) chk("bp_order", got[i], {1'b0, pre[20 + i]});

    // Byte strobes and collision
    got.delete();
    wr_en = 1'b1; wr_addr = 10'd8; wr_data = 32'h1234_5678; wr_strb = 4'b0101;
    req_valid = 1'b1; req_addr = 10'd8;
    tick();
    wr_en = 1'b0;
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    chk("strb_count", got.size(), 2);
    chk("collision_old", got[0], {1'b0, 32'hFFFF_FFFF});
    chk("strb_merge", got[1], {1'b0, 32'hFF34_FF78});

    // Out of range
    got.delete();
    req_valid = 1'b1; req_addr = 10'd1023; tick();
    req_addr = 10'd512; tick();
    req_addr = 10'd511; tick();
    req_valid = 1'b0;
    wr(10'd600, 32'hDEAD_BEEF, 4'hf);
    req_valid = 1'b1; req_addr = 10'd88; tick();
    req_valid = 1'b0;
    repeat (5) tick();
    chk("oor_count", got.size(), 4);
    chk("oor_1023", got[0], {1'b1, 32'h0});
    chk("oor_512", got[1], {1'b1, 32'h0});
    chk("oor_511_err", got[2][32], 0);
    chk("oor_write_ignored", got[3], {1'b0, 32'hA5A5_A5A5});

    // Flush
    got.delete();
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      req_valid = 1'b1; req_addr = 10'(i);
      tick();
    end
    flush = 1'b1; req_addr = 10'd3;
    @(negedge clk);
    chk("flush_req_ready", req_ready, 0);
    tick();
    flush = 1'b0; req_valid = 1'b0;
    @(negedge clk);
    chk("flush_rsp_valid", rsp_valid, 0);
    tick();
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_addr = 10'd9;
    tick();
    req_valid = 1'b0;
    repeat (4) tick();
    chk("flush_count", got.size(), 1);
    chk("flush_own_data", got[0], {1'b0, pre[9]});

    // Randomised traffic
    for (int c = 0; c < 400; c++) begin
      req_valid = ($urandom_range(0, 3) != 0);
      req_addr  = ($urandom_range(0, 5) == 0) ? 10'($urandom_range(512, 1023))
                                              : 10'($urandom_range(0, 31));
      rsp_ready = ($urandom_range(0, 9) < 7);
      wr_en     = ($urandom_range(0, 9) == 0);
      wr_addr   = ($urandom_range(0, 7) == 0) ? 10'($urandom_range(512, 1023))
                                              : 10'($urandom_range(16, 31));
      wr_data   = $urandom;
      wr_strb   = 4'($urandom_range(0, 15));
      flush     = ($urandom_range(0, 29) == 0);
      tick();
    end
    wr_en = 1'b0; flush = 1'b0; req_valid = 1'b0; rsp_ready = 1'b1;
    repeat (6) tick();

    // Asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) begin
      req_valid = 1'b1; req_addr = 10'($urandom_range(0, 15));
      tick();
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", rsp_valid, 0);
    chk("arst_rsp_data", rsp_data, 0);
    chk("arst_rsp_err", rsp_err, 0);
    req_valid = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("arst_release_valid", rsp_valid, 0);
    chk("arst_release_ready", req_ready, 1);
    tick();
    req_valid = 1'b1; req_addr = 10'd5;
    tick();
    req_valid = 1'b0;
    tick();
    @(negedge clk);
    chk("arst_mem_kept", rsp_data, 32'h0050_0093);
    repeat (3) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/instr_mem_stream.md
# instr_mem_stream

Parametrised, pipelined instruction memory for the fetch stage. It adds several things to the single-cycle latched-read memory:
- a valid/ready request/response handshake;
- a response FIFO that absorbs fetch-stage stalls;
- a byte-strobed program-load write port;
- out-of-range detection;
- a flush for branch redirects.

It sits between the PC/fetch unit and the decode stage.

## Interface

Parameters:
- DATA_BITS, default `DATA_BITS (32): instruction word width. Must be a multiple of 8.
- ADDR_BITS, default 10: word-address width.
- MEM_SIZE, default 1024: number of words, ≤ 2^ADDR_BITS.
- RSP_DEPTH, default 4: response FIFO entries. Minimum 2; at least 3 gives one fetch per cycle.

Ports (name, direction, width, meaning):
- clk, in, 1: the single clock.
- rst_n, in, 1: reset. Asynchronous, active-low.
- req_valid, in, 1: fetch request.
- req_ready, out, 1: request accepted when req_valid && req_ready.
- req_addr, in, ADDR_BITS: word address of the fetch.
- rsp_valid, out, 1: response available.
- rsp_ready, in, 1: consumer takes the response.
- rsp_data, out, DATA_BITS: instruction word.
- rsp_err, out, 1: fetch address ≥ MEM_SIZE.
- wr_en, in, 1: program-load write.
- wr_addr, in, ADDR_BITS: write word address.
- wr_data, in, DATA_BITS: write data.
- wr_strb, in, DATA_BITS/8: byte enables; bit i covers byte i.
- flush, in, 1: discard all in-flight and queued responses.

## Operation

- Storage is a MEM_SIZE × DATA_BITS array with no reset. Contents come from the write port or from bench preload.
- Write port:
  - When wr_en is high, each byte with wr_strb[i]=1 is written at the clock edge.
  - If wr_addr ≥ MEM_SIZE, the write is ignored.
- Read:
  - An accepted request registers Memory[req_addr] into a one-entry read stage and sets inflight=1.
  - The next cycle, the read stage pushes {data, err} into the FIFO.
  - For an out-of-range request, the pushed entry is data=0, err=1.
- Read/write collision: same address in the same cycle is read-first, so the response carries the old word.
- Credit rule: req_ready = !flush && (cnt + inflight < RSP_DEPTH). This term is registered-state only; there is no combinational path from rsp_ready. A full FIFO therefore never overflows.
- FIFO:
  - Circular buffer with rd_ptr, wr_ptr and cnt. Pointers wrap at RSP_DEPTH, which need not be a power of two.
  - rsp_valid = (cnt != 0). rsp_data and rsp_err are the head entry.
  - A push and a pop in the same cycle leave cnt unchanged.
  - While rsp_valid && !rsp_ready, rsp_data and rsp_err hold stable.
- Flush, when high in cycle N:
  - cnt←0, rd_ptr←wr_ptr, inflight←0.
  - The read stage's data is not pushed.
  - req_ready is 0 in cycle N, so no request is accepted.
  - rsp_valid=0 from N+1.
  - A pop in cycle N is allowed, since the consumer sees the head before the edge.
- Reset, asynchronous whenever rst_n=0 (including mid-transfer):
  - cnt=0, pointers=0, inflight=0.
  - rsp_valid=0, rsp_data=0, rsp_err=0.
  - req_ready=1 on the first cycle after release.
  - Memory is unchanged.

## Timing

- Latency: request accepted at edge N → rsp_valid in cycle N+2 if the FIFO was empty. Queued responses return strictly in request order.
- Throughput: one accept per cycle in steady state with rsp_ready=1 and RSP_DEPTH ≥ 3. With RSP_DEPTH=2 it is 2 per 3 cycles.
- Backpressure: when rsp_ready=0, at most RSP_DEPTH requests are outstanding (cnt + inflight). req_ready falls in the cycle after the last credit is consumed.
- Write → read: a write at edge N is visible to a read accepted at edge N+1 or later.

## Structure

- DATA_BITS stays in def.v. Add IMEM_ADDR_BITS and IMEM_SIZE there as the shared defaults.
- Sub-module instr_rsp_fifo holds the FIFO: parametrised width DATA_BITS+1 and depth RSP_DEPTH, with push/pop/flush, cnt, and head outputs.
- The top level holds the array, byte-strobe write, read stage, credit logic and range check.

## Test plan

- Reset and first fetch:
  - Preload word 5 = 0x00500093.
  - Hold rst_n=0 → rsp_valid=0, rsp_data=0, req_ready=1 after release.
  - Request addr 5 at edge N → rsp_valid=1, rsp_data=0x00500093, rsp_err=0 in cycle N+2.
- Streaming: addresses 0..15 back-to-back with rsp_ready=1 and RSP_DEPTH=4 → 16 responses on consecutive cycles, in order, req_ready never low.
- Backpressure:
  - Hold rsp_ready=0 and issue 6 requests → exactly 4 accepted, req_ready=0, head data stable.
  - Release rsp_ready → the remaining 2 are accepted. All 6 return in order with none lost or duplicated.
- Byte strobes and collision:
  - Word 8 = 0xFFFFFFFF. Write 0x12345678 with strb 0b0101 → the read returns 0xFF34FF78.
  - A same-cycle read of word 8 during that write returns 0xFFFFFFFF.
- Out of range: a request to addr 1023 with MEM_SIZE=512 → rsp_err=1, rsp_data=0. A write to 600 leaves the array unchanged.
- Flush and async reset:
  - With 3 queued and 1 in flight, pulse flush → rsp_valid=0 next cycle. The next request returns only its own data.
  - Drop rst_n mid-stream → outputs are 0 immediately. After release the FIFO is empty.
